// File: rtl/adc_fft_if_fft_loader.sv
// ADC-to-FFT input stage: converts unsigned ADC samples to signed 16-bit reals and
// writes one frame into the FFT RAM, optionally bit-reversed, then waits for the FFT.
module adc_fft_if_fft_loader #(
  parameter int ADC_W    = 12,
  parameter int PTS_LOG2 = 8,
  parameter int BITREV   = 1
) (
  input  logic                CLK,
  input  logic                NGRST,
  input  logic                enable,
  input  logic                adc_valid,
  input  logic [ADC_W-1:0]    adc_data,
  input  logic                fft_done,
  output logic [31:0]         wD,
  output logic [PTS_LOG2-1:0] wAddr,
  output logic                wEn,
  output logic                wBlk,
  output logic                frame_start,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    START,
    WAIT_FFT
  } state_t;

  localparam int SHIFT = 16 - ADC_W;

  state_t              state, next_state;
  logic [PTS_LOG2-1:0] idx;
  logic [PTS_LOG2-1:0] rev_idx;
  logic [PTS_LOG2-1:0] wr_addr;
  logic [ADC_W-1:0]    signed_code;
  logic [15:0]         real_val;
  logic                accept;
  logic                drop;
  logic                last_idx;

  assign accept   = enable && adc_valid && (state == FILL);
  assign drop     = enable && adc_valid && (state != FILL);
  assign last_idx = (idx == {PTS_LOG2{1'b1}});

  // Subtracting the mid-scale offset from an unsigned code is an MSB flip.
  assign signed_code = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
  assign real_val    = 16'(signed_code) << SHIFT;

  always_comb begin
    rev_idx = '0;
    for (int i = 0; i < PTS_LOG2; i++) begin
      rev_idx[i] = idx[PTS_LOG2-1-i];
    end
  end

  assign wr_addr = (BITREV != 0) ? rev_idx : idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:     next_state = FILL;
        FILL:     if (accept && last_idx) next_state = START;
        START:    next_state = WAIT_FFT;
        WAIT_FFT: if (fft_done) next_state = FILL;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Index only advances on accepted samples; any time outside FILL it sits at zero,
  // which also covers the wrap after the last sample and the abort path.
  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST)                        idx <= '0;
    else if (!enable || state != FILL) idx <= '0;
    else if (adc_valid)                idx <= idx + 1'b1;
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      wEn         <= 1'b0;
      wD          <= '0;
      wAddr       <= '0;
      frame_start <= 1'b0;
    end else begin
      wEn         <= accept;
      frame_start <= (state == START);
      if (accept) begin
        wD    <= {16'h0000, real_val};
        wAddr <= wr_addr;
      end
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST)                            overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end

  assign wBlk = wEn;
  assign busy = (state == START) || (state == WAIT_FFT);

endmodule

// File: tb/tb_adc_fft_if_fft_loader.sv
// Directed bench for adc_fft_if_fft_loader (ADC_W=12, PTS_LOG2=8, BITREV=1) with
// hand-computed expected write addresses, data words and control timing.
module tb_adc_fft_if_fft_loader;

  logic        CLK = 1'b0;
  logic        NGRST;
  logic        enable;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic        fft_done;
  logic [31:0] wD;
  logic [7:0]  wAddr;
  logic        wEn;
  logic        wBlk;
  logic        frame_start;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_count = 0;
  int fs_count  = 0;
  int wen_base;
  int fs_base;

  adc_fft_if_fft_loader #(.ADC_W(12), .PTS_LOG2(8), .BITREV(1)) dut (
    .CLK         (CLK),
    .NGRST       (NGRST),
    .enable      (enable),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .fft_done    (fft_done),
    .wD          (wD),
    .wAddr       (wAddr),
    .wEn         (wEn),
    .wBlk        (wBlk),
    .frame_start (frame_start),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (wEn)         wen_count++;
    if (frame_start) fs_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the active edge.
  task automatic step(input logic v, input logic [11:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge CLK);
    #1;
  endtask

  logic [7:0]  exp_addr [4] = '{8'h00, 8'h80, 8'h40, 8'hC0};
  logic [31:0] exp_data [4] = '{32'h0000_8000, 32'h0000_8010, 32'h0000_8020, 32'h0000_8030};

  initial begin
    NGRST = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = '0; fft_done = 1'b0;
    #12;
    check("rst_wD", wD, 0);
    check("rst_wAddr", 32'(wAddr), 0);
    check("rst_wEn", 32'(wEn), 0);
    check("rst_wBlk", 32'(wBlk), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun_cnt), 0);

    // Reset asserted mid-FILL while a write is on the outputs.
    NGRST = 1'b1; enable = 1'b1;
    step(0, 12'h000);
    step(1, 12'h123);
    step(1, 12'h124);
    step(1, 12'h125);
    check("pre_rst_wEn", 32'(wEn), 1);
    #1 NGRST = 1'b0;
    #1;
    check("async_rst_wEn", 32'(wEn), 0);
    check("async_rst_wBlk", 32'(wBlk), 0);
    check("async_rst_wD", wD, 0);
    check("async_rst_wAddr", 32'(wAddr), 0);
    NGRST = 1'b1;
    step(0, 12'h000);
    step(1, 12'h123);
    check("post_rst_wEn", 32'(wEn), 1);
    check("post_rst_wAddr", 32'(wAddr), 32'h00);
    check("post_rst_wD", wD, 32'h0000_9230);

    // Restart cleanly, then one full bit-reversed frame with data = idx.
    enable = 1'b0;
    step(0, 12'h000);
    enable = 1'b1;
    step(0, 12'h000);
    wen_base = wen_count;
    fs_base  = fs_count;
    for (int i = 0; i < 256; i++) begin
      step(1, 12'(i));
      if (i < 4) begin
        check($sformatf("f1_wAddr_%0d", i), 32'(wAddr), 32'(exp_addr[i]));
        check($sformatf("f1_wD_%0d", i), wD, exp_data[i]);
        check($sformatf("f1_wBlk_%0d", i), 32'(wBlk), 1);
      end
      if (i == 200) check("f1_busy_mid", 32'(busy), 0);
    end
    check("f1_last_wEn", 32'(wEn), 1);
    check("f1_last_wAddr", 32'(wAddr), 32'hFF);
    check("f1_last_wD", wD, 32'h0000_8FF0);
    check("f1_busy_t1", 32'(busy), 1);
    check("f1_fs_t1", 32'(frame_start), 0);
    step(0, 12'h000);
    check("f1_fs_t2", 32'(frame_start), 1);
    check("f1_wEn_t2", 32'(wEn), 0);
    check("f1_wen_total", 32'(wen_count - wen_base), 256);
    step(0, 12'h000);
    check("f1_fs_t3", 32'(frame_start), 0);
    check("f1_busy_wait", 32'(busy), 1);
    check("f1_fs_total", 32'(fs_count - fs_base), 1);

    // Strobes while waiting on the FFT are dropped and counted.
    wen_base = wen_count;
    step(1, 12'h111);
    step(1, 12'h111);
    step(1, 12'h111);
    check("ovr_3", 32'(overrun_cnt), 3);
    check("ovr_busy", 32'(busy), 1);

    // Strobe on every cycle across fft_done; fft_done-cycle strobe is an overrun.
    fft_done = 1'b1;
    step(1, 12'h222);
    fft_done = 1'b0;
    check("bnd_ovr", 32'(overrun_cnt), 4);
    check("bnd_wEn", 32'(wEn), 0);
    check("bnd_busy", 32'(busy), 0);
    check("bnd_no_writes", 32'(wen_count - wen_base), 0);
    step(1, 12'h000);
    check("ext0_wEn", 32'(wEn), 1);
    check("ext0_wAddr", 32'(wAddr), 32'h00);
    check("ext0_wD", wD, 32'h0000_8000);
    step(1, 12'h800);
    check("ext1_wAddr", 32'(wAddr), 32'h80);
    check("ext1_wD", wD, 32'h0000_0000);
    step(1, 12'hFFF);
    check("ext2_wAddr", 32'(wAddr), 32'h40);
    check("ext2_wD", wD, 32'h0000_7FF0);

    // Abort after 100 samples; strobes with enable low are neither written nor counted.
    fs_base = fs_count;
    for (int i = 3; i < 100; i++) step(1, 12'(i));
    check("abort_last_wAddr", 32'(wAddr), 32'hC6);
    enable = 1'b0;
    step(1, 12'h333);
    check("abort_wEn", 32'(wEn), 0);
    for (int i = 0; i < 5; i++) step(1, 12'h333);
    fft_done = 1'b1;
    step(1, 12'h333);
    fft_done = 1'b0;
    check("abort_ovr", 32'(overrun_cnt), 4);
    check("abort_busy", 32'(busy), 0);
    step(0, 12'h000);
    check("abort_no_fs", 32'(fs_count - fs_base), 0);
    enable = 1'b1;
    step(0, 12'h000);

    // Second frame restarts at idx 0.
    wen_base = wen_count;
    for (int i = 0; i < 256; i++) begin
      step(1, 12'(255 - i));
      if (i == 0) begin
        check("f2_first_wAddr", 32'(wAddr), 32'h00);
        check("f2_first_wD", wD, 32'h0000_8FF0);
      end
      if (i == 1) check("f2_second_wAddr", 32'(wAddr), 32'h80);
    end
    check("f2_busy", 32'(busy), 1);
    step(0, 12'h000);
    check("f2_fs", 32'(frame_start), 1);
    check("f2_wen_total", 32'(wen_count - wen_base), 256);

    // 300 strobes in WAIT_FFT saturate the overrun counter.
    wen_base = wen_count;
    for (int i = 0; i < 300; i++) step(1, 12'h444);
    check("sat_ovr", 32'(overrun_cnt), 255);
    check("sat_no_writes", 32'(wen_count - wen_base), 0);
    check("sat_busy", 32'(busy), 1);
    fft_done = 1'b1;
    step(0, 12'h000);
    fft_done = 1'b0;
    check("rel_busy", 32'(busy), 0);
    step(1, 12'h800);
    check("rel_wEn", 32'(wEn), 1);
    check("rel_wAddr", 32'(wAddr), 32'h00);
    check("rel_wD", wD, 32'h0000_0000);
    check("rel_ovr", 32'(overrun_cnt), 255);
    step(0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_fft_if_fft_loader.md
# adc_fft_if_fft_loader

Input stage of the ADC-to-FFT path. It captures unsigned ADC samples from a free-running strobe, converts them to signed 16-bit real values with zero imaginary part, and writes one 256-point frame into the in-place FFT data RAM write port, in bit-reversed order when configured. It then starts the FFT and holds off until the FFT releases the buffer. Samples that arrive while the buffer is owned by the FFT are dropped and counted.

## Interface
- ADC_W, 12: ADC sample width in bits, 8..16.
- PTS_LOG2, 8: log2 of frame length; also the RAM address width.
- BITREV, 1: 1 = write address is the bit-reversed sample index; 0 = natural order.

- CLK  in  1  single clock for the whole block.
- NGRST  in  1  asynchronous active-low reset.
- enable  in  1  level; loader runs while high.
- adc_valid  in  1  one-cycle strobe; adc_data is valid this cycle; no backpressure.
- adc_data  in  ADC_W  unsigned ADC code.
- fft_done  in  1  one-cycle pulse; FFT has finished with the buffer.
- wD  out  32  RAM write data: [31:16] imag, [15:0] real.
- wAddr  out  PTS_LOG2  RAM write address.
- wEn  out  1  RAM write enable, active high.
- wBlk  out  1  RAM write block select, active high; equal to wEn.
- frame_start  out  1  one-cycle pulse; frame is complete in RAM.
- busy  out  1  high in START and WAIT_FFT.
- overrun_cnt  out  8  dropped-sample count; saturates at 255.

## Operation
- **States:**
  - IDLE: when enable=1, go to FILL. Sample index idx clears on entry.
  - FILL: each adc_valid accepts one sample. When accepted with idx = 2^PTS_LOG2−1, go to START. Otherwise idx increments.
  - START: one cycle, then go to WAIT_FFT.
  - WAIT_FFT: on fft_done, go to FILL with idx=0.
- **enable=0** in any state: go to IDLE next cycle and clear idx.
  - If this happens in FILL, the partial frame is abandoned and no frame_start is issued.
  - If this happens in WAIT_FFT, a later fft_done is ignored.
- **Conversion** of an accepted sample:
  - s = adc_data − 2^(ADC_W−1), as signed ADC_W bits.
  - real = s << (16−ADC_W).
  - wD = {16'h0000, real}.
  - Example, ADC_W=12: 0x000→0x8000, 0x800→0x0000, 0xFFF→0x7FF0.
- **Address:** wAddr = BITREV ? bitreverse(idx) : idx. For PTS_LOG2=8: idx 1→0x80, idx 3→0xC0.
- **Overrun:** adc_valid while enable=1 and state ≠ FILL increments overrun_cnt, saturating at 255.
  - Not counted: strobes while enable=0.
  - Cleared only by reset.
- **fft_done** outside WAIT_FFT is ignored.

## Timing
- **Reset values:** wD=0, wAddr=0, wEn=0, wBlk=0, frame_start=0, busy=0, overrun_cnt=0, state=IDLE, idx=0.
- **Write latency:** adc_valid accepted at cycle t → wEn, wBlk, wD and wAddr registered and high during cycle t+1 only. No combinational path from inputs to outputs.
- **Frame end:**
  - Last sample accepted at t → its write occurs at t+1.
  - State is START during t+1; frame_start pulses at t+2.
  - busy goes high at t+1.
- **FFT release:** fft_done at cycle u (in WAIT_FFT) → FILL from u+1, busy=0 from u+1. An adc_valid at u+1 is accepted as idx 0.
- **Simultaneous events:**
  - adc_valid in the same cycle as the FILL→START transition is the last accepted sample.
  - adc_valid in START or WAIT_FFT is counted as overrun, including in the fft_done cycle.
  - enable falling in the same cycle as the last-sample adc_valid takes priority: the sample is not written and the state goes to IDLE.
- **Reset mid-operation** returns all outputs to reset values immediately. A write pending in the pipeline is not issued.
- **Throughput:** one sample per cycle sustained. adc_valid on consecutive cycles gives consecutive writes.

## Test plan
- **Reset:** assert NGRST low mid-FILL with adc_valid active → all outputs 0 asynchronously. After release with enable=1, the first write is wAddr=0x00.
- **Full frame, BITREV=1, ADC_W=12:** 256 samples with data=idx → writes for idx 0,1,2,3 at wAddr 0x00,0x80,0x40,0xC0. wD for idx 1 = 0x00008010. Exactly 256 wEn pulses. frame_start exactly 2 cycles after the last adc_valid. busy high until fft_done.
- **Conversion extremes:** data 0x000, 0x800, 0xFFF → wD 0x00008000, 0x00000000, 0x00007FF0.
- **Overrun:** 300 adc_valid strobes during WAIT_FFT → overrun_cnt=255, no wEn. After fft_done, the next strobe writes wAddr=0x00.
- **Abort:** drop enable after 100 samples, then re-raise → no frame_start. Next frame writes restart at idx 0. overrun_cnt unchanged.
- **Boundary:** adc_valid on every cycle across fft_done → the strobe in the fft_done cycle is counted as overrun. The strobe in the next cycle is written at wAddr=0x00 one cycle later.
